// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file and trap sequencer: executes Zicsr ops, ECALL/EBREAK/MRET,
// and issues a pc redirect on trap entry and return.
//
// state | meaning
// IDLE  | ready for a request; fields captured on accept
// EXEC  | CSR read/modify/write, mepc capture on trap, MRET mstatus update
// TRAP2 | trap entry: mcause and mstatus update
// RESP  | one-cycle response / redirect pulse
module csr_trap_unit #(
    parameter int unsigned     XLEN        = 64,
    parameter logic [XLEN-1:0] MSTATUS_RST = 64'ha00001800,
    parameter logic [XLEN-1:0] MTVEC_RST   = '0,
    parameter bit              HAS_MCYCLE  = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_op,
    input  logic [2:0]      req_funct3,
    input  logic [11:0]     req_csr_addr,
    input  logic [XLEN-1:0] req_rs1_data,
    input  logic [4:0]      req_zimm,
    input  logic [XLEN-1:0] req_pc,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_illegal,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc
);

    localparam logic [1:0] OP_CSR    = 2'd0;
    localparam logic [1:0] OP_ECALL  = 2'd1;
    localparam logic [1:0] OP_EBREAK = 2'd2;
    localparam logic [1:0] OP_MRET   = 2'd3;

    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MSCRATCH = 12'h340;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;
    localparam logic [11:0] A_MCYCLE   = 12'hB00;

    // only MIE (bit 3) and MPIE (bit 7) are software-writable
    localparam logic [XLEN-1:0] MS_WMASK = XLEN'(8'h88);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_EXEC  = 2'd1,
        S_TRAP2 = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [1:0]      op_q;
    logic [2:0]      f3_q;
    logic [11:0]     addr_q;
    logic [XLEN-1:0] rs1_q;
    logic [4:0]      zimm_q;
    logic [XLEN-3:0] pc_q;

    logic [XLEN-1:0] mstatus, mtvec, mepc, mcause, mscratch, mcycle;

    logic            is_trap;
    logic            csr_hit;
    logic            illegal;
    logic            csr_we;
    logic [XLEN-1:0] old_val;
    logic [XLEN-1:0] src;
    logic [XLEN-1:0] wdata;
    logic [XLEN-1:0] cause;

    assign req_ready = (state == S_IDLE);
    assign is_trap   = (op_q == OP_ECALL) || (op_q == OP_EBREAK);
    assign cause     = (op_q == OP_ECALL) ? XLEN'(11) : XLEN'(3);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (req_valid) state_nxt = S_EXEC;
            S_EXEC:  state_nxt = is_trap ? S_TRAP2 : S_RESP;
            S_TRAP2: state_nxt = S_RESP;
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        old_val = '0;
        csr_hit = 1'b1;
        case (addr_q)
            A_MSTATUS:  old_val = mstatus;
            A_MTVEC:    old_val = mtvec;
            A_MSCRATCH: old_val = mscratch;
            A_MEPC:     old_val = mepc;
            A_MCAUSE:   old_val = mcause;
            A_MCYCLE: begin
                if (HAS_MCYCLE) old_val = mcycle;
                else            csr_hit = 1'b0;
            end
            default:    csr_hit = 1'b0;
        endcase
    end

    always_comb begin
        src   = f3_q[2] ? {{(XLEN-5){1'b0}}, zimm_q} : rs1_q;
        wdata = src;
        case (f3_q[1:0])
            2'b10:   wdata = old_val | src;
            2'b11:   wdata = old_val & ~src;
            default: wdata = src;
        endcase
    end

    assign illegal = !csr_hit || (f3_q[1:0] == 2'b00);
    // set/clear forms with rs1/zimm == 0 are pure reads
    assign csr_we  = (state == S_EXEC) && (op_q == OP_CSR) && !illegal
                     && !(f3_q[1] && (zimm_q == 5'd0));

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q   <= OP_CSR;
            f3_q   <= '0;
            addr_q <= '0;
            rs1_q  <= '0;
            zimm_q <= '0;
            pc_q   <= '0;
        end else if (state == S_IDLE && req_valid) begin
            op_q   <= req_op;
            f3_q   <= req_funct3;
            addr_q <= req_csr_addr;
            rs1_q  <= req_rs1_data;
            zimm_q <= req_zimm;
            pc_q   <= req_pc[XLEN-1:2];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mstatus  <= MSTATUS_RST;
            mtvec    <= MTVEC_RST;
            mepc     <= '0;
            mcause   <= '0;
            mscratch <= '0;
            mcycle   <= '0;
        end else begin
            if (!HAS_MCYCLE) begin
                mcycle <= '0;
            end else if (csr_we && addr_q == A_MCYCLE) begin
                mcycle <= wdata;
            end else begin
                mcycle <= mcycle + XLEN'(1);
            end

            if (csr_we) begin
                case (addr_q)
                    A_MSTATUS:  mstatus  <= (mstatus & ~MS_WMASK) | (wdata & MS_WMASK);
                    A_MTVEC:    mtvec    <= wdata;
                    A_MSCRATCH: mscratch <= wdata;
                    A_MEPC:     mepc     <= {wdata[XLEN-1:2], 2'b00};
                    A_MCAUSE:   mcause   <= wdata;
                    default: ;
                endcase
            end

            if (state == S_EXEC && op_q == OP_MRET) begin
                mstatus[3]     <= mstatus[7];
                mstatus[7]     <= 1'b1;
                mstatus[12:11] <= 2'b11;
            end

            if (state == S_EXEC && is_trap) begin
                mepc <= {pc_q, 2'b00};
            end

            if (state == S_TRAP2) begin
                mcause         <= cause;
                mstatus[7]     <= mstatus[3];
                mstatus[3]     <= 1'b0;
                mstatus[12:11] <= 2'b11;
            end
        end
    end

    // outputs are loaded on the transition into RESP and cleared otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid     <= 1'b0;
            resp_rdata     <= '0;
            resp_illegal   <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            resp_valid     <= 1'b0;
            resp_rdata     <= '0;
            resp_illegal   <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            if (state == S_EXEC && op_q == OP_CSR) begin
                resp_valid   <= 1'b1;
                resp_rdata   <= illegal ? '0 : old_val;
                resp_illegal <= illegal;
            end else if (state == S_EXEC && op_q == OP_MRET) begin
                resp_valid     <= 1'b1;
                redirect_valid <= 1'b1;
                redirect_pc    <= mepc;
            end else if (state == S_TRAP2) begin
                resp_valid     <= 1'b1;
                redirect_valid <= 1'b1;
                redirect_pc    <= {mtvec[XLEN-1:2], 2'b00};
            end
        end
    end

endmodule

// File: tb/tb_csr_trap_unit.sv
// Directed bench for csr_trap_unit: expectations are queued at issue and compared
// against the response pulse, with mcycle predicted from the bench's own cycle count.
module tb_csr_trap_unit;

    localparam logic [1:0] OP_CSR    = 2'd0;
    localparam logic [1:0] OP_ECALL  = 2'd1;
    localparam logic [1:0] OP_EBREAK = 2'd2;
    localparam logic [1:0] OP_MRET   = 2'd3;

    localparam logic [63:0] MS_RST = 64'ha00001800;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = '0;
    logic [2:0]  req_funct3 = '0;
    logic [11:0] req_csr_addr = '0;
    logic [63:0] req_rs1_data = '0;
    logic [4:0]  req_zimm = '0;
    logic [63:0] req_pc = '0;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_illegal;
    logic        redirect_valid;
    logic [63:0] redirect_pc;

    csr_trap_unit #(
        .XLEN(64), .MSTATUS_RST(64'ha00001800), .MTVEC_RST(64'd0), .HAS_MCYCLE(1'b1)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_funct3(req_funct3), .req_csr_addr(req_csr_addr),
        .req_rs1_data(req_rs1_data), .req_zimm(req_zimm), .req_pc(req_pc),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_illegal(resp_illegal),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] rdata;
        logic        ill;
        logic        rv;
        logic [63:0] rpc;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_errors = 0;
    int last_acc = 0;
    int mc_base_cyc = 0;
    logic [63:0] mc_base_val = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // mcycle value seen by a request issued now (accepted at the next edge)
    function automatic logic [63:0] mcycle_exp();
        return mc_base_val + 64'(cyc + 1 - mc_base_cyc);
    endfunction

    task automatic do_req(input string tag, input logic [1:0] op, input logic [2:0] f3,
                          input logic [11:0] addr, input logic [63:0] rs1,
                          input logic [4:0] zimm, input logic [63:0] pc,
                          input logic [63:0] e_rdata, input logic e_ill,
                          input logic e_rv, input logic [63:0] e_rpc);
        exp_t e;
        exp_t got;
        int lat;
        int exp_lat;
        e.rdata = e_rdata; e.ill = e_ill; e.rv = e_rv; e.rpc = e_rpc;
        sb.push_back(e);
        exp_lat = (op == OP_ECALL || op == OP_EBREAK) ? 2 : 1;
        check({tag, ".ready_idle"}, 64'(req_ready), 64'd1);
        req_op = op; req_funct3 = f3; req_csr_addr = addr;
        req_rs1_data = rs1; req_zimm = zimm; req_pc = pc;
        req_valid = 1'b1;
        @(posedge clk); #1;
        last_acc = cyc;
        req_valid = 1'b0;
        req_rs1_data = 64'hBAD0_BAD0_BAD0_BAD0;
        check({tag, ".ready_busy"}, 64'(req_ready), 64'd0);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!resp_valid && lat < 6);
        check({tag, ".latency"}, 64'(lat), 64'(exp_lat));
        got = sb.pop_front();
        if (resp_valid) begin
            check({tag, ".rdata"}, resp_rdata, got.rdata);
            check({tag, ".illegal"}, 64'(resp_illegal), 64'(got.ill));
            check({tag, ".redir_valid"}, 64'(redirect_valid), 64'(got.rv));
            check({tag, ".redir_pc"}, redirect_pc, got.rpc);
        end
        @(posedge clk); #1;
        check({tag, ".pulse_end"}, 64'(resp_valid), 64'd0);
    endtask

    task automatic csr(input string tag, input logic [2:0] f3, input logic [11:0] addr,
                       input logic [63:0] rs1, input logic [4:0] zimm,
                       input logic [63:0] e_rdata, input logic e_ill);
        do_req(tag, OP_CSR, f3, addr, rs1, zimm, 64'd0, e_rdata, e_ill, 1'b0, 64'd0);
    endtask

    // CSRRS with rs1=x0 but garbage rs1 data: must read without writing
    task automatic rd(input string tag, input logic [11:0] addr, input logic [63:0] e_rdata);
        csr(tag, 3'b010, addr, 64'hFFFF_FFFF_FFFF_FFFF, 5'd0, e_rdata, 1'b0);
    endtask

    task automatic trap(input string tag, input logic [1:0] op, input logic [63:0] pc,
                        input logic [63:0] e_rpc);
        do_req(tag, op, 3'b000, 12'h000, 64'd0, 5'd0, pc, 64'd0, 1'b0, 1'b1, e_rpc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        mc_base_cyc = cyc;
        mc_base_val = '0;
        check("rst.ready", 64'(req_ready), 64'd1);
        check("rst.resp_valid", 64'(resp_valid), 64'd0);
        check("rst.rdata", resp_rdata, 64'd0);
        check("rst.illegal", 64'(resp_illegal), 64'd0);
        check("rst.redir_valid", 64'(redirect_valid), 64'd0);
        check("rst.redir_pc", redirect_pc, 64'd0);
        rst = 1'b0;

        // reset values, and set form with rs1=x0 does not write
        rd("t1.mstatus", 12'h300, MS_RST);
        rd("t1.mstatus_again", 12'h300, MS_RST);
        rd("t1.mcycle", 12'hB00, mcycle_exp());

        // mtvec with mode bits, then ECALL
        csr("t2.w_mtvec", 3'b001, 12'h305, 64'h8000_0103, 5'd7, 64'd0, 1'b0);
        trap("t2.ecall", OP_ECALL, 64'h8000_0010, 64'h8000_0100);
        rd("t2.mepc", 12'h341, 64'h8000_0010);
        rd("t2.mcause", 12'h342, 64'd11);
        rd("t2.mstatus", 12'h300, MS_RST);

        // CSRRSI sets MIE, MRET moves MPIE into MIE
        csr("t3.rsi", 3'b110, 12'h300, 64'd0, 5'd8, MS_RST, 1'b0);
        trap("t3.mret", OP_MRET, 64'h0, 64'h8000_0010);
        rd("t3.mstatus", 12'h300, 64'ha00001880);

        // EBREAK with MIE=1 saves it to MPIE; misaligned pc is forced aligned
        csr("t3.rsi2", 3'b110, 12'h300, 64'd0, 5'd8, 64'ha00001880, 1'b0);
        trap("t3.ebreak", OP_EBREAK, 64'h8000_0047, 64'h8000_0100);
        rd("t3.mepc_b", 12'h341, 64'h8000_0044);
        rd("t3.mcause_b", 12'h342, 64'd3);
        rd("t3.mstatus_b", 12'h300, 64'ha00001880);
        trap("t3.mret2", OP_MRET, 64'h0, 64'h8000_0044);
        rd("t3.mstatus_c", 12'h300, 64'ha00001888);

        // WARL: mstatus writes touch only MIE/MPIE, mepc low bits read 0
        csr("warl.ms_all", 3'b001, 12'h300, 64'hFFFF_FFFF_FFFF_FFFF, 5'd1, 64'ha00001888, 1'b0);
        rd("warl.ms_rd", 12'h300, 64'ha00001888);
        csr("warl.ms_zero", 3'b001, 12'h300, 64'd0, 5'd1, 64'ha00001888, 1'b0);
        rd("warl.ms_rd2", 12'h300, MS_RST);
        csr("warl.mepc_w", 3'b001, 12'h341, 64'h1237, 5'd1, 64'h8000_0044, 1'b0);
        rd("warl.mepc_rd", 12'h341, 64'h1234);

        // mscratch RW / RC / RC-with-x0 / RWI
        csr("ms.rw", 3'b001, 12'h340, 64'hFFFF, 5'd2, 64'd0, 1'b0);
        csr("ms.rc", 3'b011, 12'h340, 64'h00F0, 5'd5, 64'hFFFF, 1'b0);
        csr("ms.rc_x0", 3'b011, 12'h340, 64'h00FF, 5'd0, 64'hFF0F, 1'b0);
        rd("ms.rd", 12'h340, 64'hFF0F);
        csr("ms.rwi", 3'b101, 12'h340, 64'hDEAD, 5'h1F, 64'hFF0F, 1'b0);
        rd("ms.rd2", 12'h340, 64'h1F);

        // illegal address and bad funct3 leave state alone
        csr("t4.bad_addr", 3'b011, 12'h7C0, 64'h1, 5'd1, 64'd0, 1'b1);
        csr("t4.f3_000", 3'b000, 12'h340, 64'h5, 5'd1, 64'd0, 1'b1);
        csr("t4.f3_100", 3'b100, 12'h340, 64'h5, 5'd1, 64'd0, 1'b1);
        rd("t4.ms_rd", 12'h340, 64'h1F);
        rd("t4.mtvec_rd", 12'h305, 64'h8000_0103);

        // mcycle write then wrap through zero
        csr("t5.w_mcycle", 3'b001, 12'hB00, 64'hFFFF_FFFF_FFFF_FFFE, 5'd1, mcycle_exp(), 1'b0);
        mc_base_cyc = last_acc + 1;
        mc_base_val = 64'hFFFF_FFFF_FFFF_FFFE;
        rd("t5.mcycle_wrap", 12'hB00, mcycle_exp());
        rd("t5.mcycle_after", 12'hB00, mcycle_exp());

        // reset during TRAP2 aborts silently
        check("t6.ready_idle", 64'(req_ready), 64'd1);
        req_op = OP_ECALL; req_pc = 64'h8000_0200; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        mc_base_cyc = cyc;
        mc_base_val = '0;
        check("t6.resp_valid", 64'(resp_valid), 64'd0);
        check("t6.redir_valid", 64'(redirect_valid), 64'd0);
        check("t6.ready", 64'(req_ready), 64'd1);
        rst = 1'b0;
        @(posedge clk); #1;
        check("t6.resp_valid_next", 64'(resp_valid), 64'd0);
        check("t6.redir_valid_next", 64'(redirect_valid), 64'd0);
        check("t6.ready_next", 64'(req_ready), 64'd1);
        rd("t6.mstatus", 12'h300, MS_RST);
        rd("t6.mtvec", 12'h305, 64'd0);
        rd("t6.mepc", 12'h341, 64'd0);
        rd("t6.mcause", 12'h342, 64'd0);
        rd("t6.mscratch", 12'h340, 64'd0);
        rd("t6.mcycle", 12'hB00, mcycle_exp());

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
